// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS memory responder
package mips_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RCAP,
    WR,
    RESP
  } memstate_t;

  localparam int BYTES_PER_WORD = 4;

  // Index of the final byte of a word transfer.
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  // Big-endian byte select: offset 0 is the most significant byte.
  function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    b = w[7:0];
    case (k)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mips_mem_responder.sv
// rtl/mips_mem_responder.sv - word request to big-endian byte-port memory responder
module mips_mem_responder
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        memready,
  output logic        busy,
  output logic [31:0] ext_addr,
  output logic        ext_re,
  output logic        ext_we,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata
);

  memstate_t   state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wd_q, wd_d;
  logic        cap_q, cap_d;
  logic [31:0] shreg_q, shreg_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;

  // State register plus the byte counter, capture pipeline and held port values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      adr_q   <= 32'd0;
      wd_q    <= 32'd0;
      cap_q   <= 1'b0;
      shreg_q <= 32'd0;
      rdata_q <= 32'd0;
      addr_q  <= 32'd0;
      wdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      adr_q   <= adr_d;
      wd_q    <= wd_d;
      cap_q   <= cap_d;
      shreg_q <= shreg_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state logic and byte-port strobes decoded from the current state.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    adr_d     = adr_q;
    wd_d      = wd_q;
    shreg_d   = shreg_q;
    rdata_d   = rdata_q;
    ext_re    = 1'b0;
    ext_we    = 1'b0;
    ext_addr  = addr_q;
    ext_wdata = wdata_q;

    // Read data returns one cycle after its strobe; shift it in MSB first.
    if (cap_q) begin
      shreg_d = {shreg_q[23:0], ext_rdata};
    end

    case (state_q)
      IDLE: begin
        // Write wins when both requests are present.
        if (memwrite) begin
          state_d = WR;
          adr_d   = adr & 32'hFFFF_FFFC;
          wd_d    = writedata;
          k_d     = 2'd0;
        end else if (memread) begin
          state_d = RD;
          adr_d   = adr & 32'hFFFF_FFFC;
          wd_d    = writedata;
          k_d     = 2'd0;
        end
      end
      RD: begin
        ext_re   = 1'b1;
        ext_addr = {adr_q[31:2], k_q};
        k_d      = k_q + 2'd1;
        if (k_q == LAST_BYTE) begin
          state_d = RCAP;
        end
      end
      RCAP: begin
        // The last byte is on ext_rdata now; assemble the word directly.
        rdata_d = {shreg_q[23:0], ext_rdata};
        state_d = RESP;
      end
      WR: begin
        ext_we    = 1'b1;
        ext_addr  = {adr_q[31:2], k_q};
        ext_wdata = be_byte(wd_q, k_q);
        k_d       = k_q + 2'd1;
        if (k_q == LAST_BYTE) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cap_d   = ext_re;
    addr_d  = ext_addr;
    wdata_d = ext_wdata;
  end

  assign readdata = rdata_q;
  assign memready = (state_q == RESP);
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mips_mem_responder.sv
// tb/tb_mips_mem_responder.sv - scoreboard bench for the MIPS memory responder
module tb_mips_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        memready;
  logic        busy;
  logic [31:0] ext_addr;
  logic        ext_re;
  logic        ext_we;
  logic [7:0]  ext_wdata;
  logic [7:0]  ext_rdata;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int          cyc;
    bit          we;
    logic [31:0] addr;
    logic [7:0]  data;
  } bus_t;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
  } resp_t;

  bus_t  exp_bus[$];
  resp_t exp_resp[$];

  // Reference model: word-addressed memory plus the last word read.
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] last_rd = 32'd0;

  // External byte-wide device.
  logic [7:0] dev_mem [logic [31:0]];

  mips_mem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .memread   (memread),
    .memwrite  (memwrite),
    .adr       (adr),
    .writedata (writedata),
    .readdata  (readdata),
    .memready  (memready),
    .busy      (busy),
    .ext_addr  (ext_addr),
    .ext_re    (ext_re),
    .ext_we    (ext_we),
    .ext_wdata (ext_wdata),
    .ext_rdata (ext_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] dev_byte(input logic [31:0] a);
    if (dev_mem.exists(a)) return dev_mem[a];
    return init_byte(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] wa);
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return {init_byte(wa), init_byte(wa + 1), init_byte(wa + 2), init_byte(wa + 3)};
  endfunction

  // Device: read data one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (ext_we) dev_mem[ext_addr] = ext_wdata;
    ext_rdata <= ext_re ? dev_byte(ext_addr) : 8'($urandom);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Expected bus traffic and response for one accepted request at cycle c0.
  task automatic push_exp(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input int c0);
    logic [31:0] wa;
    logic [31:0] tmp;
    logic [31:0] w;
    bus_t  b;
    resp_t r;
    wa = a & 32'hFFFF_FFFC;
    if (wr) begin
      for (int i = 0; i < 4; i++) begin
        tmp    = wd >> (24 - 8 * i);
        b.cyc  = c0 + 1 + i;
        b.we   = 1'b1;
        b.addr = wa + i;
        b.data = tmp[7:0];
        exp_bus.push_back(b);
      end
      ref_mem[wa] = wd;
      r.cyc   = c0 + 5;
      r.rdata = last_rd;
      exp_resp.push_back(r);
    end else if (rd) begin
      w = ref_read(wa);
      for (int i = 0; i < 4; i++) begin
        b.cyc  = c0 + 1 + i;
        b.we   = 1'b0;
        b.addr = wa + i;
        b.data = 8'h00;
        exp_bus.push_back(b);
      end
      last_rd = w;
      r.cyc   = c0 + 6;
      r.rdata = w;
      exp_resp.push_back(r);
    end
  endtask

  // Monitor: every strobe and every memready pulse is matched against the queues.
  always @(negedge clk) begin : monitor
    bus_t  eb;
    resp_t er;
    if (ext_re && ext_we) chk("both_strobes", 32'd1, 32'd0);
    if (ext_re || ext_we) begin
      if (exp_bus.size() == 0) begin
        chk("unexpected_strobe", {30'd0, ext_re, ext_we}, 32'd0);
      end else begin
        eb = exp_bus.pop_front();
        chk("bus_cycle", 32'(cyc), 32'(eb.cyc));
        chk("bus_we", 32'(ext_we), 32'(eb.we));
        chk("bus_re", 32'(ext_re), 32'(!eb.we));
        chk("bus_addr", ext_addr, eb.addr);
        if (eb.we) chk("bus_wdata", 32'(ext_wdata), 32'(eb.data));
      end
    end
    if (memready) begin
      if (exp_resp.size() == 0) begin
        chk("unexpected_memready", 32'd1, 32'd0);
      end else begin
        er = exp_resp.pop_front();
        chk("resp_cycle", 32'(cyc), 32'(er.cyc));
        chk("readdata", readdata, er.rdata);
      end
    end
  end

  task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    chk("idle_before_req", 32'(busy), 32'd0);
    memread   = rd;
    memwrite  = wr;
    adr       = a;
    writedata = wd;
    push_exp(rd, wr, a, wd, cyc);
  endtask

  // Wait for memready; scramble request inputs mid-transfer to show they are ignored.
  task automatic wait_done(input bit drop, output int t);
    bit found;
    found = 1'b0;
    t = -1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (memready) begin
        found = 1'b1;
        t = cyc;
        if (drop) begin
          memread  = 1'b0;
          memwrite = 1'b0;
        end
      end else if (busy) begin
        adr       = $urandom;
        writedata = $urandom;
      end
    end
    if (!found) chk("memready_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t1, t2, c0, gap, op;
    logic [31:0] a, wd;

    reset = 1'b1; memread = 1'b0; memwrite = 1'b0; adr = 32'd0; writedata = 32'd0;
    dev_mem[32'h100] = 8'h11;
    dev_mem[32'h101] = 8'h22;
    dev_mem[32'h102] = 8'h33;
    dev_mem[32'h103] = 8'h44;
    ref_mem[32'h100] = 32'h1122_3344;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_memready", 32'(memready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ext_re", 32'(ext_re), 32'd0);
    chk("rst_ext_we", 32'(ext_we), 32'd0);
    chk("rst_ext_addr", ext_addr, 32'd0);
    chk("rst_ext_wdata", 32'(ext_wdata), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_no_strobe", {30'd0, ext_re, ext_we}, 32'd0);
    end

    // Directed read, write, priority/misalignment.
    issue(1'b1, 1'b0, 32'h100, 32'h0);
    wait_done(1'b1, t1);
    issue(1'b0, 1'b1, 32'h204, 32'hDEAD_BEEF);
    wait_done(1'b1, t1);
    chk("hold_ext_addr", ext_addr, 32'h207);
    chk("hold_ext_wdata", 32'(ext_wdata), 32'hEF);
    issue(1'b1, 1'b1, 32'h103, 32'hCAFE_F00D);
    wait_done(1'b1, t1);

    // Reset in cycle 3 of a read.
    @(negedge clk);
    chk("idle_before_abort", 32'(busy), 32'd0);
    memread = 1'b1;
    adr     = 32'h2000;
    c0      = cyc;
    for (int i = 0; i < 3; i++) begin
      bus_t b;
      b.cyc = c0 + 1 + i; b.we = 1'b0; b.addr = 32'h2000 + i; b.data = 8'h00;
      exp_bus.push_back(b);
    end
    repeat (3) @(negedge clk);
    reset   = 1'b1;
    memread = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ext_re", 32'(ext_re), 32'd0);
    chk("abort_ext_we", 32'(ext_we), 32'd0);
    chk("abort_readdata", readdata, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_memready", 32'(memready), 32'd0);
    last_rd = 32'd0;
    repeat (2) @(negedge clk);
    issue(1'b1, 1'b0, 32'h100, 32'h0);
    wait_done(1'b1, t1);

    // Back-to-back loads: request held through RESP with a new address.
    issue(1'b1, 1'b0, 32'h204, 32'h0);
    wait_done(1'b0, t1);
    adr = 32'h100A;
    push_exp(1'b1, 1'b0, 32'h100A, 32'h0, t1 + 1);
    wait_done(1'b1, t2);
    chk("b2b_spacing", 32'(t2 - t1), 32'd7);

    // Randomized traffic over a small set of words.
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      a  = 32'h1000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      wd = $urandom;
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      issue(op != 2, op >= 2, a, wd);
      wait_done(1'b1, t1);
    end

    repeat (4) @(negedge clk);
    chk("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
    chk("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
